mspc_v_alu_arb: RTL

MSPC_V_ALU_ARB -- requirements
Module: mspc_v_alu_arb

---
 rtl/mspc_v_alu_arb.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mspc_v_alu_arb.sv
// Two-requester round-robin front end for a single shared ALU.
// One operation in flight: IDLE -> EXEC (one ALU cycle) -> RESP.
module mspc_v_alu_arb #(
    parameter int         WIDTH    = 64,
    parameter logic [3:0] IDLE_SEL = 4'b1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_num,
    output logic             rsp_bool,
    output logic             rsp_err,
    output logic             busy,
    output logic [WIDTH-1:0] alu_inpa,
    output logic [WIDTH-1:0] alu_inpb,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_numoutp,
    input  logic             alu_booloutp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q;
    logic             lp_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       sel_q;
    logic             id_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_num_q;
    logic             rsp_bool_q;
    logic             rsp_err_q;

    logic             gnt0;
    logic             gnt1;
    logic             take;
    logic [WIDTH-1:0] num_d;
    logic             bool_d;
    logic             err_d;

    // On a tie the requester that did not win last time is granted.
    assign gnt0 = req0_valid & (~req1_valid | lp_q);
    assign gnt1 = req1_valid & (~req0_valid | ~lp_q);

    assign req0_ready = (state_q == IDLE) & ~rst & gnt0;
    assign req1_ready = (state_q == IDLE) & ~rst & gnt1;
    assign take       = req0_ready | req1_ready;

    always_comb begin
        num_d  = '0;
        bool_d = 1'b0;
        err_d  = 1'b0;
        unique case (sel_q)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5:
                num_d = alu_numoutp;
            4'd6, 4'd7, 4'd10, 4'd11, 4'd12:
                bool_d = alu_booloutp;
            default:
                err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lp_q        <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= 4'd0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_num_q   <= '0;
            rsp_bool_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (take) begin
                        a_q     <= req1_ready ? req1_a : req0_a;
                        b_q     <= req1_ready ? req1_b : req0_b;
                        sel_q   <= req1_ready ? req1_sel : req0_sel;
                        id_q    <= req1_ready;
                        lp_q    <= req1_ready;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    rsp_num_q   <= num_d;
                    rsp_bool_q  <= bool_d;
                    rsp_err_q   <= err_d;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operand registers only change on accept, so the ALU inputs hold.
    assign alu_inpa  = a_q;
    assign alu_inpb  = b_q;
    assign alu_sel   = (state_q == EXEC) ? sel_q : IDLE_SEL;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_num   = rsp_num_q;
    assign rsp_bool  = rsp_bool_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

endmodule
